fir_dpc_mc: RTL

//  Parametrised multi-channel datapath controller for the FIR filter core.

---
 rtl/fir_dpc_mc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fir_dpc_mc.sv
// Multi-channel FIR datapath controller: one tap per cycle, NCH channels time-multiplexed.
// Define DPC_PERF_EN to add the samples_out/stalls_out performance counters.

package fir_dpc_pkg;
   typedef enum logic [1:0] {DMEM_READ = 2'd0, DMEM_SHIFT = 2'd1, DMEM_CLEAR = 2'd2} dmem_cmd_t;
   typedef enum logic [1:0] {ALU_NOP = 2'd0, ALU_MU = 2'd1, ALU_ADMU = 2'd2, ALU_SATA = 2'd3} alu_cmd_t;
   typedef enum logic [1:0] {ACC_NOP = 2'd0, ACC_LOAD = 2'd1, ACC_CLEAR = 2'd2} acc_cmd_t;
endpackage

module fir_dpc_mc
   import fir_dpc_pkg::*;
#(
   parameter int NTAPS = 5,
   parameter int NCH = 1,
   localparam int DMEMSIZE = NCH * NTAPS,
   localparam int KW = $clog2(NTAPS),
   localparam int AW = $clog2(DMEMSIZE),
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_in,
   input  logic          prog_in,
   input  logic          extvalid_in,
   input  logic          extready_in,
   output logic [KW-1:0] cmem_addr,
   output dmem_cmd_t     dmem_cmd,
   output logic [AW-1:0] dmem_addr,
   output alu_cmd_t      alu_cmd,
   output acc_cmd_t      acc_cmd,
   output logic          extvalid_out,
   output logic [CW-1:0] ch_out,
   output logic          busy_out
`ifdef DPC_PERF_EN
   ,
   output logic [15:0]   samples_out,
   output logic [15:0]   stalls_out
`endif
);

   typedef enum logic [2:0] {
      StStopped, StProgram, StClear, StExtin, StTap, StSat, StExtout
   } state_e;

   localparam logic [KW-1:0] KLast = KW'(NTAPS - 1);
   localparam logic [CW-1:0] CLast = CW'(NCH - 1);

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [AW-1:0] base;

   assign base   = AW'(32'(ch_q) * 32'(NTAPS));
   assign ch_out = ch_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StStopped;
         k_q     <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ch_q    <= ch_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      ch_d         = ch_q;
      cmem_addr    = '0;
      dmem_cmd     = DMEM_READ;
      dmem_addr    = '0;
      alu_cmd      = ALU_NOP;
      acc_cmd      = ACC_NOP;
      extvalid_out = 1'b0;
      busy_out     = 1'b1;
      unique case (state_q)
         StStopped: begin
            busy_out = 1'b0;
            if (prog_in) state_d = StProgram;
            else if (start_in) state_d = StExtin;
         end
         StProgram: begin
            busy_out = 1'b0;
            if (!prog_in) state_d = StClear;
         end
         StClear: begin
            dmem_cmd = DMEM_CLEAR;
            acc_cmd  = ACC_CLEAR;
            ch_d     = '0;
            state_d  = StStopped;
         end
         StExtin: begin
            // Stop wins over a coincident sample; the shift is issued in the accepting cycle.
            if (!start_in) begin
               state_d = StStopped;
            end else if (extvalid_in) begin
               dmem_cmd  = DMEM_SHIFT;
               dmem_addr = base;
               k_d       = '0;
               state_d   = StTap;
            end
         end
         StTap: begin
            cmem_addr = k_q;
            dmem_addr = base + AW'(k_q);
            acc_cmd   = ACC_LOAD;
            alu_cmd   = (k_q == '0) ? ALU_MU : ALU_ADMU;
            if (k_q == KLast) state_d = StSat;
            else k_d = k_q + KW'(1);
         end
         StSat: begin
            alu_cmd = ALU_SATA;
            acc_cmd = ACC_LOAD;
            state_d = StExtout;
         end
         StExtout: begin
            extvalid_out = 1'b1;
            if (extready_in) begin
               ch_d    = (ch_q == CLast) ? '0 : ch_q + CW'(1);
               state_d = StExtin;
            end
         end
         default: state_d = StStopped;
      endcase
   end

`ifdef DPC_PERF_EN
   logic [15:0] samples_q, stalls_q;
   logic        in_out;

   assign in_out      = (state_q == StExtout);
   assign samples_out = samples_q;
   assign stalls_out  = stalls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samples_q <= '0;
         stalls_q  <= '0;
      end else if (state_q == StClear) begin
         samples_q <= '0;
         stalls_q  <= '0;
      end else if (in_out && extready_in) begin
         samples_q <= samples_q + 16'd1;
      end else if (in_out && (stalls_q != 16'hFFFF)) begin
         stalls_q  <= stalls_q + 16'd1;
      end
   end
`endif

endmodule
